// File: rtl/gmii_tx_arbiter.sv
// Two-source, frame-granular round-robin arbiter for the GMII transmit path.
// Enforces the inter-frame gap, flags underrun, and jams/drains collided frames in half duplex.
module gmii_tx_arbiter #(
    parameter int unsigned IFG_BYTES = 12,
    parameter int unsigned JAM_BYTES = 4,
    parameter logic [7:0]  JAM_DATA  = 8'h55
) (
    input  logic       gmii_tx_clk,
    input  logic       reset,
    input  logic       duplex_mode,
    input  logic       gmii_col,
    input  logic       s0_req,
    input  logic [7:0] s0_data,
    input  logic       s0_valid,
    input  logic       s0_last,
    output logic       s0_ready,
    output logic       s0_grant,
    output logic       s0_abort,
    input  logic       s1_req,
    input  logic [7:0] s1_data,
    input  logic       s1_valid,
    input  logic       s1_last,
    output logic       s1_ready,
    output logic       s1_grant,
    output logic       s1_abort,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       underrun
);

    typedef enum logic [2:0] {IDLE, XMIT, JAM, DRAIN, IFG} state_t;

    state_t     state, state_nxt;
    logic       gsel, gsel_nxt;
    logic       last_grant, last_grant_nxt;
    logic       started, started_nxt;
    logic       last_taken, last_taken_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [7:0] txd_nxt;
    logic       en_nxt, er_nxt, urun_nxt;
    logic       abort_q, abort_nxt;

    logic       sel_valid, sel_last, owned, rdy, acc, col_hit;
    logic [7:0] sel_data;

    assign sel_valid = gsel ? s1_valid : s0_valid;
    assign sel_last  = gsel ? s1_last  : s0_last;
    assign sel_data  = gsel ? s1_data  : s0_data;

    assign owned = (state == XMIT) || (state == JAM) || (state == DRAIN);
    assign rdy   = (state == XMIT) || (state == DRAIN);
    assign acc   = rdy & sel_valid;

    // Collision only matters once real bytes are on the wire and only in half duplex.
    assign col_hit = (state == XMIT) && started && !duplex_mode && gmii_col;

    assign s0_grant = owned & ~gsel;
    assign s1_grant = owned &  gsel;
    assign s0_ready = rdy & ~gsel;
    assign s1_ready = rdy &  gsel;
    assign s0_abort = abort_q & ~gsel;
    assign s1_abort = abort_q &  gsel;

    always_comb begin
        state_nxt      = state;
        gsel_nxt       = gsel;
        last_grant_nxt = last_grant;
        started_nxt    = started;
        last_taken_nxt = last_taken;
        cnt_nxt        = cnt;
        txd_nxt        = 8'h00;
        en_nxt         = 1'b0;
        er_nxt         = 1'b0;
        urun_nxt       = underrun;
        abort_nxt      = 1'b0;
        case (state)
            IDLE: begin
                started_nxt    = 1'b0;
                last_taken_nxt = 1'b0;
                if (s0_req | s1_req) begin
                    gsel_nxt       = (s0_req & s1_req) ? ~last_grant : s1_req;
                    last_grant_nxt = gsel_nxt;
                    state_nxt      = XMIT;
                end
            end
            XMIT: begin
                if (acc) begin
                    txd_nxt     = sel_data;
                    en_nxt      = 1'b1;
                    started_nxt = 1'b1;
                    if (sel_last) begin
                        last_taken_nxt = 1'b1;
                        state_nxt      = IFG;
                        cnt_nxt        = 8'(IFG_BYTES);
                    end
                end else if (started) begin
                    en_nxt   = 1'b1;
                    er_nxt   = 1'b1;
                    urun_nxt = 1'b1;
                end
                // A byte taken in the collision cycle still goes out; jam follows it.
                if (col_hit) begin
                    state_nxt = JAM;
                    cnt_nxt   = 8'(JAM_BYTES);
                    abort_nxt = 1'b1;
                end
            end
            JAM: begin
                txd_nxt = JAM_DATA;
                en_nxt  = 1'b1;
                if (cnt <= 8'd1) begin
                    if (last_taken) begin
                        state_nxt = IFG;
                        cnt_nxt   = 8'(IFG_BYTES);
                    end else begin
                        state_nxt = DRAIN;
                    end
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            DRAIN: begin
                if (acc && sel_last) begin
                    state_nxt = IFG;
                    cnt_nxt   = 8'(IFG_BYTES);
                end
            end
            IFG: begin
                if (cnt <= 8'd1) state_nxt = IDLE;
                else             cnt_nxt   = cnt - 8'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge gmii_tx_clk) begin
        if (reset) begin
            state      <= IDLE;
            gsel       <= 1'b0;
            last_grant <= 1'b1;
            started    <= 1'b0;
            last_taken <= 1'b0;
            cnt        <= 8'h00;
            gmii_txd   <= 8'h00;
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
            underrun   <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state      <= state_nxt;
            gsel       <= gsel_nxt;
            last_grant <= last_grant_nxt;
            started    <= started_nxt;
            last_taken <= last_taken_nxt;
            cnt        <= cnt_nxt;
            gmii_txd   <= txd_nxt;
            gmii_tx_en <= en_nxt;
            gmii_tx_er <= er_nxt;
            underrun   <= urun_nxt;
            abort_q    <= abort_nxt;
        end
    end

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Directed bench for gmii_tx_arbiter: per-cycle source model, GMII log, hand-derived expectations.
module tb_gmii_tx_arbiter;

    localparam int MAXC = 512;

    logic       gmii_tx_clk = 1'b0;
    logic       reset = 1'b1, duplex_mode = 1'b1, gmii_col = 1'b0;
    logic       s0_req = 1'b0, s0_valid = 1'b0, s0_last = 1'b0;
    logic       s1_req = 1'b0, s1_valid = 1'b0, s1_last = 1'b0;
    logic [7:0] s0_data = 8'h00, s1_data = 8'h00;
    logic       s0_ready, s1_ready, s0_grant, s1_grant, s0_abort, s1_abort;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en, gmii_tx_er, underrun;

    gmii_tx_arbiter #(.IFG_BYTES(12), .JAM_BYTES(4), .JAM_DATA(8'h55)) dut (
        .gmii_tx_clk(gmii_tx_clk), .reset(reset), .duplex_mode(duplex_mode), .gmii_col(gmii_col),
        .s0_req(s0_req), .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last),
        .s0_ready(s0_ready), .s0_grant(s0_grant), .s0_abort(s0_abort),
        .s1_req(s1_req), .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last),
        .s1_ready(s1_ready), .s1_grant(s1_grant), .s1_abort(s1_abort),
        .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er), .underrun(underrun)
    );

    always #5 gmii_tx_clk = ~gmii_tx_clk;

    int n_chk = 0, n_err = 0;

    // source model
    int f_cnt[2], f_len[2], f_base[2], idx[2];
    int stall_at[2], stall_n[2], stall_c[2], first_acc[2], last_acc[2];
    int col_idx = -1;

    // GMII / grant log, one entry per cycle
    int         cyc = 0;
    logic [7:0] l_txd [MAXC];
    logic       l_en [MAXC], l_er [MAXC], l_g0 [MAXC], l_g1 [MAXC];
    logic       l_a0 [MAXC], l_a1 [MAXC], l_rng [MAXC];

    int nb, b_st[16], b_len[16];
    int c_er, c_a0, c_a1, c_g0, c_g1, c_rng, a0_pos;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int nlog();
        return (cyc < MAXC) ? cyc : MAXC;
    endfunction

    function automatic logic [7:0] txd_at(input int i);
        if (i >= 0 && i < MAXC) return l_txd[i];
        return 8'hxx;
    endfunction

    function automatic logic er_at(input int i);
        if (i >= 0 && i < MAXC) return l_er[i];
        return 1'bx;
    endfunction

    task automatic step();
        logic       rdy [2];
        logic       q   [2];
        logic       v   [2];
        logic [7:0] d   [2];
        logic       l   [2];
        @(negedge gmii_tx_clk);
        if (cyc < MAXC) begin
            l_txd[cyc] = gmii_txd;  l_en[cyc] = gmii_tx_en; l_er[cyc] = gmii_tx_er;
            l_g0[cyc]  = s0_grant;  l_g1[cyc] = s1_grant;
            l_a0[cyc]  = s0_abort;  l_a1[cyc] = s1_abort;
            l_rng[cyc] = (s0_ready & ~s0_grant) | (s1_ready & ~s1_grant);
        end
        rdy[0] = s0_ready;
        rdy[1] = s1_ready;
        gmii_col = 1'b0;
        for (int s = 0; s < 2; s++) begin
            q[s] = (f_cnt[s] > 0);
            v[s] = 1'b0;
            d[s] = 8'(f_base[s] + idx[s]);
            l[s] = (idx[s] == f_len[s] - 1);
            if (q[s]) begin
                if (idx[s] == stall_at[s] && stall_c[s] < stall_n[s]) begin
                    if (rdy[s] === 1'b1) stall_c[s]++;
                end else begin
                    v[s] = 1'b1;
                end
            end
            if (s == 0 && v[s] && rdy[s] === 1'b1 && idx[s] == col_idx) begin
                gmii_col = 1'b1;
                col_idx  = -1;
            end
            if (v[s] && rdy[s] === 1'b1) begin
                if (first_acc[s] < 0) first_acc[s] = cyc;
                last_acc[s] = cyc;
                idx[s]++;
                if (idx[s] == f_len[s]) begin
                    idx[s] = 0;
                    f_cnt[s]--;
                    stall_c[s] = 0;
                end
            end
        end
        s0_req = q[0]; s0_valid = v[0]; s0_data = d[0]; s0_last = l[0];
        s1_req = q[1]; s1_valid = v[1]; s1_data = d[1]; s1_last = l[1];
        cyc++;
    endtask

    task automatic clear_model();
        for (int s = 0; s < 2; s++) begin
            f_cnt[s] = 0; f_len[s] = 1; f_base[s] = 0; idx[s] = 0;
            stall_at[s] = -1; stall_n[s] = 0; stall_c[s] = 0;
            first_acc[s] = -1; last_acc[s] = -1;
        end
        col_idx = -1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_model();
        step();
        step();
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic run_until_done(input string tag, input int extra);
        int g = 0;
        while ((f_cnt[0] > 0 || f_cnt[1] > 0) && g < 600) begin
            step();
            g++;
        end
        chk(tag, g < 600, 1'b1);
        repeat (extra) step();
    endtask

    task automatic find_bursts();
        nb = 0;
        for (int i = 0; i < nlog(); i++) begin
            if (l_en[i] === 1'b1) begin
                if (i == 0 || l_en[i-1] !== 1'b1) begin
                    nb++;
                    if (nb <= 16) begin b_st[nb-1] = i; b_len[nb-1] = 0; end
                end
                if (nb <= 16) b_len[nb-1]++;
            end
        end
    endtask

    task automatic tally();
        c_er = 0; c_a0 = 0; c_a1 = 0; c_g0 = 0; c_g1 = 0; c_rng = 0; a0_pos = -1;
        for (int i = 0; i < nlog(); i++) begin
            if (l_er[i]  === 1'b1) c_er++;
            if (l_a1[i]  === 1'b1) c_a1++;
            if (l_g0[i]  === 1'b1) c_g0++;
            if (l_g1[i]  === 1'b1) c_g1++;
            if (l_rng[i] !== 1'b0) c_rng++;
            if (l_a0[i]  === 1'b1) begin
                if (a0_pos < 0) a0_pos = i;
                c_a0++;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int e, gs, prev0, prev1, seq_bad;
        logic [7:0] exp_b;

        // ---- reset state
        do_reset();
        chk("rst_tx_en", gmii_tx_en, 0);
        chk("rst_txd", gmii_txd, 0);
        chk("rst_tx_er", gmii_tx_er, 0);
        chk("rst_grant_ready_abort", {s0_grant, s1_grant, s0_ready, s1_ready, s0_abort, s1_abort}, 0);
        chk("rst_underrun", underrun, 0);

        // ---- single 64-byte frame from s0
        f_cnt[0] = 1; f_len[0] = 64; f_base[0] = 0;
        run_until_done("t1_timeout", 20);
        find_bursts(); tally();
        chk("t1_bursts", nb, 1);
        chk("t1_len", b_len[0], 64);
        chk("t1_latency", b_st[0], first_acc[0] + 1);
        e = 0;
        for (int i = 0; i < 64; i++) begin
            exp_b = 8'(i);
            if (txd_at(b_st[0] + i) !== exp_b) e++;
        end
        chk("t1_data", e, 0);
        chk("t1_er", c_er, 0);
        chk("t1_s1_grant", c_g1, 0);
        chk("t1_tail_idle", (nlog() - (b_st[0] + 64)) >= 12, 1'b1);

        // ---- both sources contending, 4 x 8-byte frames each
        do_reset();
        f_cnt[0] = 4; f_len[0] = 8; f_base[0] = 8'h10;
        f_cnt[1] = 4; f_len[1] = 8; f_base[1] = 8'h80;
        run_until_done("t2_timeout", 20);
        find_bursts(); tally();
        chk("t2_bursts", nb, 8);
        e = 0;
        for (int i = 0; i < 8 && i < nb; i++) begin
            if (b_len[i] != 8) e++;
            for (int j = 0; j < 8; j++) begin
                exp_b = 8'(((i % 2) ? 8'h80 : 8'h10) + j);
                if (txd_at(b_st[i] + j) !== exp_b) e++;
            end
        end
        chk("t2_burst_data", e, 0);
        e = 0;
        for (int i = 0; i + 1 < nb && i < 15; i++)
            if (b_st[i+1] - (b_st[i] + b_len[i]) != 13) e++;
        chk("t2_gap13", e, 0);
        gs = 0; seq_bad = 0; prev0 = 0; prev1 = 0;
        for (int i = 0; i < nlog(); i++) begin
            if (l_g0[i] === 1'b1 && prev0 == 0) begin
                if (gs % 2 != 0) seq_bad++;
                gs++;
            end
            if (l_g1[i] === 1'b1 && prev1 == 0) begin
                if (gs % 2 != 1) seq_bad++;
                gs++;
            end
            prev0 = (l_g0[i] === 1'b1) ? 1 : 0;
            prev1 = (l_g1[i] === 1'b1) ? 1 : 0;
        end
        chk("t2_grant_count", gs, 8);
        chk("t2_grant_alternate", seq_bad, 0);
        chk("t2_ready_wo_grant", c_rng, 0);
        chk("t2_underrun", underrun, 0);

        // ---- s1 underrun: 3-cycle valid gap after 5 bytes of a 16-byte frame
        do_reset();
        f_cnt[1] = 1; f_len[1] = 16; f_base[1] = 8'h40;
        stall_at[1] = 5; stall_n[1] = 3;
        run_until_done("t3_timeout", 20);
        find_bursts(); tally();
        chk("t3_bursts", nb, 1);
        chk("t3_len", b_len[0], 19);
        chk("t3_er_count", c_er, 3);
        e = 0;
        for (int j = 0; j < 19; j++) begin
            if (j < 5)      exp_b = 8'(8'h40 + j);
            else if (j < 8) exp_b = 8'h00;
            else            exp_b = 8'(8'h40 + j - 3);
            if (txd_at(b_st[0] + j) !== exp_b) e++;
            if (er_at(b_st[0] + j) !== ((j >= 5 && j < 8) ? 1'b1 : 1'b0)) e++;
        end
        chk("t3_pattern", e, 0);
        chk("t3_s0_grant", c_g0, 0);
        chk("t3_underrun_sticky", underrun, 1);

        // ---- half duplex collision at byte 10 of a 40-byte s0 frame; s1 waiting
        do_reset();
        chk("t4_underrun_cleared", underrun, 0);
        duplex_mode = 1'b0;
        col_idx = 10;
        f_cnt[0] = 1; f_len[0] = 40; f_base[0] = 0;
        f_cnt[1] = 1; f_len[1] = 4;  f_base[1] = 8'hA0;
        run_until_done("t4_timeout", 10);
        find_bursts(); tally();
        chk("t4_bursts", nb, 2);
        chk("t4_len", b_len[0], 15);
        e = 0;
        for (int j = 0; j < 15; j++) begin
            exp_b = (j < 11) ? 8'(j) : 8'h55;
            if (txd_at(b_st[0] + j) !== exp_b) e++;
        end
        chk("t4_jam_data", e, 0);
        chk("t4_abort_count", c_a0, 1);
        chk("t4_abort_s1", c_a1, 0);
        chk("t4_abort_at", a0_pos, b_st[0] + 10);
        chk("t4_grant_span", c_g0, last_acc[0] - first_acc[0] + 1);
        chk("t4_ifg", b_st[1] - last_acc[0], 15);
        chk("t4_s1_first", txd_at(b_st[1]), 8'hA0);
        chk("t4_ready_wo_grant", c_rng, 0);

        // ---- same collision in full duplex: ignored
        do_reset();
        duplex_mode = 1'b1;
        col_idx = 10;
        f_cnt[0] = 1; f_len[0] = 40; f_base[0] = 0;
        f_cnt[1] = 1; f_len[1] = 4;  f_base[1] = 8'hA0;
        run_until_done("t5_timeout", 10);
        find_bursts(); tally();
        chk("t5_len", b_len[0], 40);
        e = 0;
        for (int j = 0; j < 40; j++) begin
            exp_b = 8'(j);
            if (txd_at(b_st[0] + j) !== exp_b) e++;
        end
        chk("t5_data", e, 0);
        chk("t5_abort", c_a0 + c_a1, 0);
        chk("t5_ifg", b_st[1] - last_acc[0], 15);

        // ---- reset mid-frame, then simultaneous request
        do_reset();
        f_cnt[0] = 1; f_len[0] = 40; f_base[0] = 0;
        gs = 0;
        while (idx[0] < 20 && gs < 200) begin
            step();
            gs++;
        end
        chk("t6_reach_byte20", idx[0], 20);
        reset = 1'b1;
        step();
        chk("t6_tx_en_after_rst", gmii_tx_en, 0);
        chk("t6_grants_after_rst", {s0_grant, s1_grant}, 0);
        clear_model();
        f_cnt[0] = 1; f_len[0] = 4; f_base[0] = 8'hC0;
        f_cnt[1] = 1; f_len[1] = 4; f_base[1] = 8'hD0;
        step();
        reset = 1'b0;
        step();
        chk("t6_tie_winner", {s0_grant, s1_grant}, 2'b10);
        chk("t6_underrun", underrun, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
